tcnt_timer_param: RTL

//  Parametrised successor of the 8-bit TCNT timer: WIDTH-bit up/down counter with its own prescaler.

---
 rtl/tcnt_pkg.sv | 22 ++
 rtl/tcnt_timer_param_if.sv | 28 ++
 rtl/tcnt_prescaler.sv | 53 +++++
 rtl/tcnt_timer_param.sv | 111 +++++++++++
 4 files changed

// File: rtl/tcnt_pkg.sv
// Shared constants for the parametrised TCNT timer.
//  - TCR bit positions (load, auto-reload, direction, enable, one-shot)
//  - flag vector bit positions {cmp, undf, ovf}
//  - run-control FSM state type
package tcnt_pkg;

  localparam int TCR_LOAD = 7;
  localparam int TCR_ARLD = 6;
  localparam int TCR_DOWN = 5;
  localparam int TCR_EN   = 4;
  localparam int TCR_OS   = 3;

  localparam int FLG_OVF  = 0;
  localparam int FLG_UNDF = 1;
  localparam int FLG_CMP  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_st_e;

endpackage

// File: rtl/tcnt_timer_param_if.sv
// Register-side bundle for the TCNT timer.
//  master : register decode (drives TDR/TCMP/TCR/Clk_SEL/flag_clr)
//  slave  : the timer (drives TCNT, the three sticky flags and irq)
interface tcnt_timer_param_if #(
  parameter int WIDTH     = 8,
  parameter int CLK_SEL_W = 2
);
  logic [WIDTH-1:0]     TDR;
  logic [WIDTH-1:0]     TCMP;
  logic [7:0]           TCR;
  logic [CLK_SEL_W-1:0] Clk_SEL;
  logic [2:0]           flag_clr;
  logic [WIDTH-1:0]     TCNT;
  logic                 over_flow;
  logic                 under_flow;
  logic                 cmp_match;
  logic                 irq;

  modport master (
    output TDR, TCMP, TCR, Clk_SEL, flag_clr,
    input  TCNT, over_flow, under_flow, cmp_match, irq
  );

  modport slave (
    input  TDR, TCMP, TCR, Clk_SEL, flag_clr,
    output TCNT, over_flow, under_flow, cmp_match, irq
  );
endinterface

// File: rtl/tcnt_prescaler.sv
// Prescaler for the TCNT timer: single-cycle tick every 2^(Clk_SEL+1) PCLKs
// while run is high.
//  PCLK    in  clock
//  RST     in  synchronous active-high reset
//  run     in  count enable; presc is held at 0 while low
//  Clk_SEL in  division select
//  clr     in  restart the division period (counter load)
//  tick    out one-PCLK count strobe
module tcnt_prescaler #(
  parameter int CLK_SEL_W = 2
) (
  input  logic                 PCLK,
  input  logic                 RST,
  input  logic                 run,
  input  logic [CLK_SEL_W-1:0] Clk_SEL,
  input  logic                 clr,
  output logic                 tick
);

  // Largest division is 2^(2^CLK_SEL_W), so the counter needs 2^CLK_SEL_W bits.
  localparam int PW = 2 ** CLK_SEL_W;

  logic [PW-1:0]        presc_q, presc_d;
  logic [PW-1:0]        term;
  logic [CLK_SEL_W-1:0] sel_q;
  logic [31:0]          shamt;
  logic                 sel_chg;

  // Terminal count 2^(Clk_SEL+1)-1 built as a low-ones mask; a shift by the
  // full width yields all ones, covering the largest division.
  assign shamt   = 32'(Clk_SEL) + 32'd1;
  assign term    = ~({PW{1'b1}} << shamt);
  assign sel_chg = (Clk_SEL != sel_q);

  // No tick on the cycle the select changes: the period restarts instead.
  assign tick = run && !sel_chg && (presc_q == term);

  always_comb begin
    presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
    if (!run || clr || sel_chg || tick) presc_d = '0;
  end

  always_ff @(posedge PCLK) begin
    if (RST) begin
      presc_q <= '0;
      sel_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sel_q   <= Clk_SEL;
    end
  end

endmodule

// File: rtl/tcnt_timer_param.sv
// WIDTH-bit up/down timer with internal prescaler, auto-reload, one-shot,
// compare match and sticky clearable flags combined into one registered irq.
//  PCLK  in  sole clock
//  RST   in  synchronous active-high reset
//  bus   slave modport: TDR, TCMP, TCR, Clk_SEL, flag_clr in;
//                       TCNT, over_flow, under_flow, cmp_match, irq out
module tcnt_timer_param
  import tcnt_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CLK_SEL_W = 2
) (
  input  logic PCLK,
  input  logic RST,
  tcnt_timer_param_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic             load_q, en_q;
  logic             load_edge, en_edge;
  run_st_e          st_q, st_d;
  logic             run, tick, wrap;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]       flg_q, flg_d, flg_set;
  logic             irq_q, irq_d;

  assign load_edge = bus.TCR[TCR_LOAD] & ~load_q;
  assign en_edge   = bus.TCR[TCR_EN]   & ~en_q;
  assign run       = (st_q == RUN);

  tcnt_prescaler #(.CLK_SEL_W(CLK_SEL_W)) u_presc (
    .PCLK    (PCLK),
    .RST     (RST),
    .run     (run),
    .Clk_SEL (bus.Clk_SEL),
    .clr     (load_edge),
    .tick    (tick)
  );

  // Counter next state. A load edge overrides a coincident tick entirely.
  always_comb begin
    cnt_d   = cnt_q;
    flg_set = '0;
    wrap    = 1'b0;
    if (load_edge) begin
      cnt_d = bus.TDR;
    end else if (tick) begin
      if (bus.TCR[TCR_DOWN]) begin
        if (cnt_q == '0) begin
          cnt_d             = bus.TCR[TCR_ARLD] ? bus.TDR : MAX;
          flg_set[FLG_UNDF] = 1'b1;
          wrap              = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end else begin
        if (cnt_q == MAX) begin
          cnt_d            = bus.TCR[TCR_ARLD] ? bus.TDR : '0;
          flg_set[FLG_OVF] = 1'b1;
          wrap             = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      if (cnt_d == bus.TCMP) flg_set[FLG_CMP] = 1'b1;
    end
  end

  // Run control: start on an enable rising edge, stop when enable drops or
  // a one-shot count wraps.
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (en_edge) st_d = RUN;
      RUN:     if (!bus.TCR[TCR_EN] || (wrap && bus.TCR[TCR_OS])) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Set beats clear so an event in the clearing cycle is never lost.
  assign flg_d = (flg_q & ~bus.flag_clr) | flg_set;
  assign irq_d = |(flg_q & bus.TCR[2:0]);

  always_ff @(posedge PCLK) begin
    if (RST) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      flg_q  <= '0;
      irq_q  <= 1'b0;
      load_q <= 1'b0;
      // Enable history resets high so an enable still asserted across reset
      // does not restart the counter; it must drop and rise again.
      en_q   <= 1'b1;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      flg_q  <= flg_d;
      irq_q  <= irq_d;
      load_q <= bus.TCR[TCR_LOAD];
      en_q   <= bus.TCR[TCR_EN];
    end
  end

  assign bus.TCNT       = cnt_q;
  assign bus.over_flow  = flg_q[FLG_OVF];
  assign bus.under_flow = flg_q[FLG_UNDF];
  assign bus.cmp_match  = flg_q[FLG_CMP];
  assign bus.irq        = irq_q;

endmodule
